load_scoreboard: RTL
====================

# load_scoreboard

Tracks loads issued to the data cache whose results have not yet returned. Produces the decode-stage stall that blocks any instruction reading or overwriting such a register. It sits beside the decode/register-file stage, upstream of the forwarding logic. A stall is released in the same cycle the data cache writes the register back, so the forwarding path supplies the value without an extra bubble.

## Interface

Parameters:
- MAX_OUTSTANDING, 4, maximum loads in flight; legal range 1..7.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- idValid  in  1  decode holds a valid instruction.
- idOperantAAddr  in  5  source register A of the decode instruction.
- idOperantBAddr  in  5  source register B, or store-data register.
- idUseImmediate  in  1  operand B is an immediate; register B is not read as an operand.
- idStore  in  3  nonzero means store; register B is read as store data.
- idLoad  in  1  decode instruction is a load.
- idDestination  in  5  destination register of the decode instruction.
- loadIssue  in  1  one-cycle pulse: a load is handed to the data cache this cycle.
- loadDestination  in  5  destination register of the issued load.
- dcacheRegisterAddress  in  9  [8:5] context id, [4:0] register of the returning load.
- dcacheRegisterWe  in  1  load-return write strobe.
- cid  in  4  context id of this core.
- scoreboardStall  out  1  hold the decode stage.
- pendingMask  out  32  registered set of registers with a load in flight.
- outstandingCount  out  3  registered number of loads in flight.
- scoreboardError  out  1  sticky protocol-violation flag.

## Operation

- **Return match.** `ret` = dcacheRegisterWe & (dcacheRegisterAddress[8:5] == cid) & (dcacheRegisterAddress[4:0] != 0). `retVec` is the one-hot of the returned register, gated by `ret`.
- **Issue.** `iss` = loadIssue & (loadDestination != 0) & (outstandingCount < MAX_OUTSTANDING). `issVec` is the one-hot of loadDestination, gated by `iss`.
- **Mask update.** Next mask = (pendingMask & ~retVec) | issVec. On a set and clear of the same register in the same cycle, the set wins.
- **Count update.** Next count = count + iss − (ret & pendingMask[ret reg]). Increment and decrement in the same cycle leave the count unchanged.
- **Register 0.** Never tracked. Loads to r0 do not change the mask or count. Returns to r0 are ignored.
- **Effective pending set.** `eff` = pendingMask & ~retVec, so a register returning this cycle counts as ready.
- **Stall terms.** scoreboardStall = idValid & (hitA | hitB | hitD | full), where:
  - hitA = (idOperantAAddr != 0) & eff[A].
  - hitB = (idOperantBAddr != 0) & (~idUseImmediate | idStore != 0) & eff[B].
  - hitD = idLoad & (idDestination != 0) & eff[D]. This prevents two in-flight loads to one register.
  - full = idLoad & (outstandingCount == MAX_OUTSTANDING).
- **Issue contract.** Upstream never asserts loadIssue for an instruction that saw scoreboardStall = 1.
- **Error conditions.** scoreboardError sets, and stays set until reset, on either:
  - `ret` for a register whose pendingMask bit is 0;
  - loadIssue with loadDestination != 0 while count == MAX_OUTSTANDING. That issue is dropped.
- **Reset.** pendingMask = 0, outstandingCount = 0, scoreboardError = 0. Reset overrides a simultaneous issue or return.

## Timing

- Mask, count and error update one clock after the triggering issue or return.
- The stall is combinational from the registered mask and the current-cycle return. Load issued at edge N:
  - a dependent decode instruction stalls from cycle N+1;
  - a return in cycle M releases the stall in cycle M itself, and the forwarding path supplies the data.
- Minimum load-to-use stall with a return k cycles after issue: k−1 cycles.
- outstandingCount is never read as wrapped. It saturates at MAX_OUTSTANDING through the issue guard and never underflows because of the pending-bit guard.
- Reset asserted mid-operation discards all in-flight tracking. Returns arriving after reset are flagged as errors.

## Test plan

- **Basic load-use.** Reset, loadIssue r5. Next cycle decode reads A=r5 → stall=1 and pendingMask=0x20. Return r5 with cid matching, two cycles later → stall=0 in the return cycle; mask=0 and count=0 one cycle later.
- **Context and immediate filtering.** Pending r3; return with dcacheRegisterAddress[8:5] ≠ cid → mask unchanged. Decode with B=r3, idUseImmediate=1, idStore=0 → no stall. Same with idStore=1 → stall=1.
- **Same-cycle set and clear.** Pending r7; r7 return and loadIssue r9 in one cycle → mask=0x200, count stays 1. Same-cycle return and issue both to r7 → mask bit 7 stays 1, count stays 1.
- **Capacity.** MAX_OUTSTANDING=4, issue loads to r1..r4 → count=4. Decode load to r10 → stall=1. Forced loadIssue r10 → dropped and error=1. One return → count=3 and the stall clears.
- **WAW and r0.** Pending r6, decode load to r6 → stall=1. loadIssue r0 → mask and count unchanged. Decode reads r0 → no stall.
- **Spurious return and reset.** Return r12 with the mask empty → error=1 next cycle. Issue r2, then reset mid-flight → mask=0, count=0, error=0. Later return r2 → error=1.

Source files
------------

// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks registers with a data-cache load in flight and raises the
// decode-stage stall for any instruction that reads or overwrites one of them.
module load_scoreboard #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        idValid,
    input  logic [4:0]  idOperantAAddr,
    input  logic [4:0]  idOperantBAddr,
    input  logic        idUseImmediate,
    input  logic [2:0]  idStore,
    input  logic        idLoad,
    input  logic [4:0]  idDestination,
    input  logic        loadIssue,
    input  logic [4:0]  loadDestination,
    input  logic [8:0]  dcacheRegisterAddress,
    input  logic        dcacheRegisterWe,
    input  logic [3:0]  cid,
    output logic        scoreboardStall,
    output logic [31:0] pendingMask,
    output logic [2:0]  outstandingCount,
    output logic        scoreboardError
);

    localparam logic [2:0] MaxCount = 3'(MAX_OUTSTANDING);

    logic [31:0] mask_q, mask_d;
    logic [2:0]  count_q, count_d;
    logic        err_q, err_d;

    logic [4:0]  ret_reg;
    logic        ret, ret_known, iss, at_cap, drop;
    logic [31:0] ret_vec, iss_vec, eff;
    logic        hit_a, hit_b, hit_d, full;

    assign ret_reg = dcacheRegisterAddress[4:0];

    // Return/issue decode and next-state for mask, count and sticky error.
    always_comb begin
        ret       = dcacheRegisterWe && (dcacheRegisterAddress[8:5] == cid) && (ret_reg != 5'd0);
        ret_known = mask_q[ret_reg];
        at_cap    = (count_q == MaxCount);
        iss       = loadIssue && (loadDestination != 5'd0) && (count_q < MaxCount);
        drop      = loadIssue && (loadDestination != 5'd0) && at_cap;

        ret_vec = '0;
        if (ret) begin
            ret_vec[ret_reg] = 1'b1;
        end
        iss_vec = '0;
        if (iss) begin
            iss_vec[loadDestination] = 1'b1;
        end

        // Set is applied after clear, so a same-register set wins.
        mask_d = (mask_q & ~ret_vec) | iss_vec;

        count_d = count_q;
        if (iss && !(ret && ret_known)) begin
            count_d = count_q + 3'd1;
        end else if (!iss && ret && ret_known) begin
            count_d = count_q - 3'd1;
        end

        err_d = err_q | (ret && !ret_known) | drop;
    end

    // A register returning this cycle is already ready thanks to forwarding.
    always_comb begin
        eff   = mask_q & ~ret_vec;
        hit_a = (idOperantAAddr != 5'd0) && eff[idOperantAAddr];
        hit_b = (idOperantBAddr != 5'd0) && (!idUseImmediate || (idStore != 3'd0))
                && eff[idOperantBAddr];
        hit_d = idLoad && (idDestination != 5'd0) && eff[idDestination];
        full  = idLoad && at_cap;
        scoreboardStall = idValid && (hit_a || hit_b || hit_d || full);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign pendingMask      = mask_q;
    assign outstandingCount = count_q;
    assign scoreboardError  = err_q;

endmodule
